conv_window_ctrl: RTL

Sequencing controller that sits between the upstream pixel source and `line_buffer` in the convolution pipeline. It accepts a framed valid/ready pixel stream, checks frame geometry, drives `line_buffer`'s write stream and synchronous reset, and produces window-valid, border and frame-event strobes aligned with `line_buffer`'s three line outputs. The 3x3 convolution stage uses these strobes to gate its column shift registers.

---
 rtl/conv_window_ctrl_if.sv | 30 +++
 rtl/conv_window_ctrl.sv | 123 ++++++++++++
 2 files changed

// File: rtl/conv_window_ctrl_if.sv
// conv_window_ctrl_if: pixel stream in, line_buffer drive and window strobes out
interface conv_window_ctrl_if;
    logic        enable;
    logic [7:0]  s_pixel;
    logic        s_valid;
    logic        s_sof;
    logic        s_eol;
    logic        s_ready;
    logic [7:0]  lb_pixel;
    logic        lb_pixel_valid;
    logic        lb_reset;
    logic        win_valid;
    logic [9:0]  win_row;
    logic [9:0]  win_col;
    logic        win_border;
    logic        frame_done;
    logic        err_line;
    logic        err_sof;
    logic [15:0] frame_count;
    modport master (
        output enable, s_pixel, s_valid, s_sof, s_eol,
        input  s_ready, lb_pixel, lb_pixel_valid, lb_reset, win_valid, win_row, win_col,
               win_border, frame_done, err_line, err_sof, frame_count
    );
    modport slave (
        input  enable, s_pixel, s_valid, s_sof, s_eol,
        output s_ready, lb_pixel, lb_pixel_valid, lb_reset, win_valid, win_row, win_col,
               win_border, frame_done, err_line, err_sof, frame_count
    );
endinterface

// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: frames a pixel stream into line_buffer and emits aligned 3x3 window strobes
module conv_window_ctrl #(
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480
) (
    input logic               clk,
    input logic               reset,
    conv_window_ctrl_if.slave bus
);
    localparam logic [2:0] IDLE = 3'd0, FILL = 3'd1, RUN = 3'd2, DONE = 3'd3, RESYNC = 3'd4;
    localparam logic [9:0] LAST_COL = 10'(IMAGE_WIDTH - 1);
    localparam logic [9:0] LAST_ROW = 10'(IMAGE_HEIGHT - 1);
    logic [2:0]  state_q, state_d;
    logic [9:0]  col_q, col_d, row_q, row_d;
    logic [7:0]  lb_pixel_q;
    logic        lb_valid_q, lb_reset_q, err_line_q, err_sof_q;
    logic        p_valid_q;
    logic [9:0]  p_row_q, p_col_q;
    logic        win_valid_q, win_border_q;
    logic [9:0]  win_row_q, win_col_q;
    logic [15:0] frame_count_q;
    logic        accept, waiting, in_frame, sof_go, last_col, bad_eol, bad_sof, fwd, pipe_win;
    assign bus.s_ready        = state_q != DONE;
    assign bus.lb_pixel       = lb_pixel_q;
    assign bus.lb_pixel_valid = lb_valid_q;
    assign bus.lb_reset       = lb_reset_q;
    assign bus.win_valid      = win_valid_q;
    assign bus.win_row        = win_row_q;
    assign bus.win_col        = win_col_q;
    assign bus.win_border     = win_border_q;
    assign bus.frame_done     = state_q == DONE;
    assign bus.err_line       = err_line_q;
    assign bus.err_sof        = err_sof_q;
    assign bus.frame_count    = frame_count_q;
    // Accept qualification, geometry checks and next position/state
    always_comb begin
        accept   = bus.s_valid && bus.s_ready;
        waiting  = state_q == IDLE || state_q == RESYNC;
        in_frame = state_q == FILL || state_q == RUN;
        last_col = col_q == LAST_COL;
        sof_go   = waiting && accept && bus.s_sof && bus.enable;
        bad_eol  = in_frame && accept && (bus.s_eol != last_col);
        bad_sof  = in_frame && accept && bus.s_sof && (col_q != 10'd0 || row_q != 10'd0);
        fwd      = sof_go || (in_frame && accept && !bad_eol && !bad_sof);
        pipe_win = p_valid_q && p_row_q >= 10'd2 && p_col_q >= 10'd2;
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        if (sof_go) begin
            state_d = FILL;
            col_d   = 10'd1;
            row_d   = 10'd0;
        end else if (bad_eol || bad_sof) begin
            state_d = RESYNC;
        end else if (fwd) begin
            if (last_col) begin
                col_d   = 10'd0;
                row_d   = row_q + 10'd1;
                state_d = row_q == LAST_ROW ? DONE : (row_d == 10'd2 ? RUN : state_q);
            end else begin
                col_d = col_q + 10'd1;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end
    // Frame state and next-expected pixel position
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end
    // line_buffer write stream, its reset, and error pulses (one cycle after accept)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lb_pixel_q <= '0;
            lb_valid_q <= 1'b0;
            lb_reset_q <= 1'b1;
            err_line_q <= 1'b0;
            err_sof_q  <= 1'b0;
        end else begin
            lb_valid_q <= fwd;
            if (fwd) lb_pixel_q <= bus.s_pixel;
            lb_reset_q <= (waiting || state_q == DONE) && !sof_go;
            err_line_q <= bad_eol;
            err_sof_q  <= bad_sof;
        end
    end
    // Two-stage window pipeline so strobes line up with line_buffer's registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_valid_q    <= 1'b0;
            p_row_q      <= '0;
            p_col_q      <= '0;
            win_valid_q  <= 1'b0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            win_border_q <= 1'b0;
        end else begin
            p_valid_q    <= fwd;
            p_row_q      <= sof_go ? 10'd0 : row_q;
            p_col_q      <= sof_go ? 10'd0 : col_q;
            win_valid_q  <= pipe_win;
            win_border_q <= pipe_win && (p_col_q == 10'd2 || p_col_q == LAST_COL ||
                                         p_row_q == 10'd2 || p_row_q == LAST_ROW);
            if (pipe_win) begin
                win_row_q <= p_row_q - 10'd1;
                win_col_q <= p_col_q - 10'd1;
            end
        end
    end
    // Completed-frame counter, bumped during the DONE cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) frame_count_q <= '0;
        else if (state_q == DONE) frame_count_q <= frame_count_q + 16'd1;
    end
endmodule
